// File: rtl/rc4_stream_xor_pkg.sv
// Shared definitions for the rc4 keystream XOR host block.
package rc4_stream_xor_pkg;
  localparam int KEY_SIZE_DEF   = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CORE_RST = 2'd1,
    FEED     = 2'd2,
    RUN      = 2'd3
  } state_t;
endpackage

// File: rtl/rc4_ks_fifo.sv
// Keystream FIFO; a push into a full FIFO with no pop is dropped and flagged.
module rc4_ks_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       drop
);
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // Full plus a simultaneous pop frees the slot being written, so no drop.
  assign drop    = push && full && !do_pop;
  assign do_push = push && !drop;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/rc4_stream_xor.sv
// Drives key load into an rc4 core, buffers its keystream and XORs it onto a data stream.
module rc4_stream_xor
  import rc4_stream_xor_pkg::*;
#(
  parameter int KEY_SIZE   = KEY_SIZE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int AW         = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rekey,
  input  logic       key_valid,
  input  logic [7:0] key_byte,
  output logic       key_ready,
  output logic       core_rst,
  output logic [7:0] password_input,
  input  logic       output_ready,
  input  logic [7:0] K,
  input  logic       din_valid,
  input  logic [7:0] din,
  output logic       din_ready,
  output logic       dout_valid,
  output logic [7:0] dout,
  input  logic       dout_ready,
  output logic       overflow
);
  localparam int            KW   = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;
  localparam logic [KW-1:0] LAST = KW'(KEY_SIZE - 1);

  state_t                     state;
  logic [KW-1:0]              key_idx, key_nxt;
  logic [KEY_SIZE-1:0][7:0]   key;
  logic                       fifo_empty, fifo_drop, ks_push, accept;
  logic [7:0]                 ks_head;

  assign key_nxt   = key_idx + 1'b1;
  assign ks_push   = (state == RUN) && !overflow && output_ready;
  assign din_ready = (state == RUN) && !overflow && !fifo_empty && (!dout_valid || dout_ready);
  assign accept    = din_valid && din_ready;

  rc4_ks_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (rekey),
    .push  (ks_push),
    .wdata (K),
    .pop   (accept),
    .head  (ks_head),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  always_ff @(posedge clk)
    if (state == IDLE && key_valid && !rekey) key[key_idx] <= key_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      key_idx        <= '0;
      key_ready      <= 1'b1;
      core_rst       <= 1'b1;
      password_input <= '0;
      overflow       <= 1'b0;
      dout_valid     <= 1'b0;
      dout           <= '0;
    end else if (rekey) begin
      state          <= IDLE;
      key_idx        <= '0;
      key_ready      <= 1'b1;
      core_rst       <= 1'b1;
      password_input <= '0;
      overflow       <= 1'b0;
      dout_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (key_valid) begin
          if (key_idx == LAST) begin
            key_idx        <= '0;
            key_ready      <= 1'b0;
            password_input <= key[0];
            state          <= CORE_RST;
          end else begin
            key_idx <= key_nxt;
          end
        end
        CORE_RST: begin
          core_rst <= 1'b0;
          state    <= FEED;
        end
        // key_idx is the byte currently on password_input.
        FEED: if (key_idx == LAST) begin
          key_idx <= '0;
          state   <= RUN;
        end else begin
          password_input <= key[key_nxt];
          key_idx        <= key_nxt;
        end
        RUN: if (fifo_drop) overflow <= 1'b1;
        default: state <= IDLE;
      endcase

      if (accept) begin
        dout       <= din ^ ks_head;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rc4_stream_xor.sv
// Bench: behavioural rc4 core + scoreboard against an RC4 keystream model.
module tb_rc4_stream_xor;
  localparam int KS = 3, DEPTH = 4, LAT = 4;

  logic       clk = 1'b0;
  logic       rst, rekey, key_valid, key_ready, core_rst;
  logic [7:0] key_byte, password_input, K, din, dout;
  logic       output_ready, din_valid, din_ready, dout_valid, dout_ready, overflow;

  always #5 clk = ~clk;

  rc4_stream_xor #(.KEY_SIZE(KS), .FIFO_DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .rst(rst), .rekey(rekey), .key_valid(key_valid), .key_byte(key_byte),
    .key_ready(key_ready), .core_rst(core_rst), .password_input(password_input),
    .output_ready(output_ready), .K(K), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .dout_valid(dout_valid), .dout(dout),
    .dout_ready(dout_ready), .overflow(overflow)
  );

  int         checks = 0, errors = 0;
  int         n_acc = 0, cyc_cnt = 0, core_mode = 0;
  bit         rnd_sink = 0, sink_en = 1;
  logic [7:0] ref_ks [256];
  logic [7:0] core_ks [256];
  logic [7:0] exp_q[$], got_q[$];
  logic [7:0] plain_q[$], ciph_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void rc4_gen(input logic [7:0] k [KS], output logic [7:0] ks [256]);
    logic [7:0] s [256];
    logic [7:0] t;
    int i, j;
    for (int a = 0; a < 256; a++) s[a] = 8'(a);
    j = 0;
    for (int a = 0; a < 256; a++) begin
      j = (j + int'(s[a]) + int'(k[a % KS])) % 256;
      t = s[a]; s[a] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int n = 0; n < 256; n++) begin
      i = (i + 1) % 256;
      j = (j + int'(s[i])) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks[n] = s[(int'(s[i]) + int'(s[j])) % 256];
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Core model: samples password_input after reset release, then emits keystream it cannot stall.
  initial begin
    logic [7:0] cap [KS];
    int ccnt, kidx, tick;
    bit emit;
    output_ready = 0; K = 0; ccnt = 0; kidx = 0; tick = 0;
    forever begin
      @(negedge clk);
      if (core_rst) begin
        ccnt = 0; kidx = 0; tick = 0; output_ready = 0;
      end else if (ccnt < KS) begin
        cap[ccnt] = password_input;
        ccnt++;
        output_ready = 0;
        if (ccnt == KS) rc4_gen(cap, core_ks);
      end else if (ccnt < KS + LAT) begin
        ccnt++;
        output_ready = 0;
      end else begin
        tick++;
        case (core_mode)
          0:       emit = 1;
          1:       emit = (tick % 4) == 0;
          default: emit = $urandom_range(0, 1) == 1;
        endcase
        output_ready = emit;
        if (emit) begin
          K = core_ks[kidx % 256];
          kidx++;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    dout_ready = rnd_sink ? ($urandom_range(0, 2) != 0) : sink_en;
  end

  // Scoreboard: push on accepted input, pop and compare on accepted output.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (din_valid && din_ready) begin
        exp_q.push_back(din ^ ref_ks[n_acc % 256]);
        n_acc++;
      end
      if (dout_valid && dout_ready) begin
        got_q.push_back(dout);
        if (exp_q.size() == 0) chk("unexpected_dout", 1, 0);
        else chk("scoreboard_dout", dout, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_core_rst", core_rst, 1);
    chk("rst_password", password_input, 0);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_overflow", overflow, 0);
  endtask

  task automatic send_key(input logic [7:0] k [KS]);
    for (int b = 0; b < KS; b++) begin
      if ($urandom_range(0, 1) == 1) begin
        key_valid = 0;
        @(negedge clk);
        chk("gap_core_rst", core_rst, 1);
        step();
      end
      key_byte = k[b]; key_valid = 1;
      @(negedge clk);
      chk("idle_key_ready", key_ready, 1);
      chk("idle_core_rst", core_rst, 1);
      step();
    end
    key_valid = 0;
  endtask

  task automatic load_key(input logic [7:0] k0, k1, k2, input bit check_feed);
    logic [7:0] k [KS];
    k = '{k0, k1, k2};
    rc4_gen(k, ref_ks);
    n_acc = 0; exp_q.delete(); got_q.delete();
    send_key(k);
    if (check_feed) begin
      @(negedge clk);
      chk("crst_core_rst", core_rst, 1);
      chk("crst_key_ready", key_ready, 0);
      chk("crst_password", password_input, k[0]);
      for (int b = 0; b < KS; b++) begin
        @(negedge clk);
        chk("feed_core_rst", core_rst, 0);
        chk("feed_password", password_input, k[b]);
      end
      @(negedge clk);
      chk("run_password_hold", password_input, k[KS-1]);
      step();
    end
  endtask

  task automatic stream(input logic [7:0] data[$], input int stall_at, input bit rnd,
                        output int first, output int last);
    int budget;
    logic [7:0] held;
    first = 0; last = 0;
    for (int b = 0; b < data.size(); b++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        din_valid = 0;
        step();
      end
      din = data[b]; din_valid = 1;
      budget = 0;
      @(negedge clk);
      while (!din_ready) begin
        if (rnd && overflow) begin
          din_valid = 0;
          step();
          return;
        end
        budget++;
        if (budget > 200) begin
          chk("din_ready_timeout", 0, 1);
          din_valid = 0;
          step();
          return;
        end
        @(negedge clk);
      end
      if (b == 0) first = cyc_cnt;
      last = cyc_cnt;
      step();
      if (b == stall_at) begin
        din_valid = 0; sink_en = 0;
        @(negedge clk);
        held = dout;
        for (int c = 0; c < 5; c++) begin
          chk("stall_dout_valid", dout_valid, 1);
          chk("stall_dout", dout, held);
          chk("stall_din_ready", din_ready, 0);
          @(negedge clk);
        end
        sink_en = 1;
        step();
      end
    end
    din_valid = 0;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      step();
      budget++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic rekey_pulse();
    rekey = 1;
    step();
    rekey = 0;
    @(negedge clk);
    chk("rekey_key_ready", key_ready, 1);
    chk("rekey_core_rst", core_rst, 1);
    chk("rekey_overflow", overflow, 0);
    chk("rekey_dout_valid", dout_valid, 0);
    chk("rekey_din_ready", din_ready, 0);
    step();
  endtask

  task automatic cmp_got(input string name, input logic [7:0] ref_q[$]);
    chk({name, "_len"}, got_q.size(), ref_q.size());
    for (int b = 0; b < ref_q.size(); b++)
      chk(name, (b < got_q.size()) ? int'(got_q[b]) : -1, ref_q[b]);
  endtask

  initial begin
    int f, l;
    logic [7:0] rk [KS];
    logic [7:0] rd[$];
    plain_q = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    ciph_q  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    rst = 0; rekey = 0; key_valid = 0; key_byte = 0; din_valid = 0; din = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    step();
    rst = 1;

    // Encrypt known vector back-to-back
    core_mode = 0;
    load_key(8'h4B, 8'h65, 8'h79, 1);
    stream(plain_q, -1, 0, f, l);
    @(negedge clk);
    chk("enc_overflow", overflow, 0);
    chk("enc_throughput", l - f, 8);
    drain();
    cmp_got("enc_cipher", ciph_q);
    rekey_pulse();

    // Decrypt with the same key
    load_key(8'h4B, 8'h65, 8'h79, 1);
    stream(ciph_q, -1, 0, f, l);
    drain();
    cmp_got("dec_plain", plain_q);
    rekey_pulse();

    // Overflow with no consumer
    load_key(8'h4B, 8'h65, 8'h79, 0);
    repeat (25) step();
    @(negedge clk);
    chk("ovf_overflow", overflow, 1);
    chk("ovf_din_ready", din_ready, 0);
    chk("ovf_fifo_level", 3'(dut.u_fifo.wr_ptr - dut.u_fifo.rd_ptr), 4);
    step();
    rekey_pulse();

    // Sink stall mid-stream with a slow keystream
    core_mode = 1;
    load_key(8'h4B, 8'h65, 8'h79, 0);
    stream(plain_q, 3, 0, f, l);
    drain();
    cmp_got("stall_cipher", ciph_q);
    chk("stall_overflow", overflow, 0);
    rekey_pulse();

    // Async reset in the middle of FEED, then a clean reload
    core_mode = 0;
    rk = '{8'h4B, 8'h65, 8'h79};
    send_key(rk);
    step();
    step();
    #2 rst = 0;
    #1 chk_reset_vals();
    step();
    rst = 1;
    load_key(8'h4B, 8'h65, 8'h79, 1);
    stream(plain_q, -1, 0, f, l);
    drain();
    cmp_got("rst_cipher", ciph_q);
    rekey_pulse();

    // Randomized keys, data, keystream gaps and sink backpressure
    core_mode = 2;
    rnd_sink = 1;
    for (int r = 0; r < 4; r++) begin
      load_key(8'($urandom), 8'($urandom), 8'($urandom), 1);
      rd.delete();
      for (int b = 0; b < 30; b++) rd.push_back(8'($urandom));
      stream(rd, -1, 1, f, l);
      drain();
      rekey_pulse();
    end
    rnd_sink = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
